// File: rtl/dff_share_arb_pkg.sv
// Shared types and constants for the dff_share_arb round-robin arbiter.
// Holds the FSM state enum, the burst counter width and the OutId width helper.
package dff_share_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int BURST_CNT_W = 4;

    // A single requester index still needs one bit on the OutId port.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dff_share_arb_rr_pick.sv
// Combinational round-robin search: first set request bit at or above 'start', wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int               pos;
    logic [IDX_W-1:0] sel;

    // Scan from the farthest candidate back to 'start' so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        sel   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            sel = IDX_W'(pos);
            if (req[sel]) begin
                found = 1'b1;
                idx   = sel;
            end
        end
    end

endmodule

// File: rtl/dff_share_arb.sv
// Round-robin arbiter sharing one registered datapath among N_REQ requesters, with burst limiting.
// Build option: define DFF_SHARE_ARB_INVERT_EN to make the datapath capture ~DataIn instead of DataIn.
module dff_share_arb
    import dff_share_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                        Clock,
    input  logic                        Reset_n,
    input  logic [N_REQ-1:0]            Req,
    input  logic [N_REQ*DATA_W-1:0]     DataIn,
    output logic [N_REQ-1:0]            Gnt,
    output logic [DATA_W-1:0]           DataOut,
    output logic                        OutValid,
    output logic [id_width(N_REQ)-1:0]  OutId,
    output logic                        Busy
);

    localparam int IDX_W = id_width(N_REQ);
    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(BURST_MAX - 1);
    localparam logic [BURST_CNT_W-1:0] BURST_SAT   = {BURST_CNT_W{1'b1}};
    localparam logic [IDX_W-1:0]       LAST_IDX    = IDX_W'(N_REQ - 1);

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       owner, owner_nxt;
    logic [IDX_W-1:0]       ptr, ptr_nxt;
    logic [BURST_CNT_W-1:0] burst_cnt, burst_nxt;
    logic [IDX_W-1:0]       owner_inc;
    logic [N_REQ-1:0]       others;
    logic                   owner_req;
    logic                   idle_found, rot_found;
    logic [IDX_W-1:0]       idle_idx, rot_idx;
    logic                   capture;
    logic [DATA_W-1:0]      slot_data, slot_fx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    assign owner_inc = wrap_inc(owner);
    assign owner_req = Req[owner];
    assign others    = Req & ~(N_REQ'(1) << owner);
    assign capture   = (state == GRANT) && owner_req;
    assign Busy      = (state == GRANT);

    rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick_idle (
        .req   (Req),
        .start (ptr),
        .found (idle_found),
        .idx   (idle_idx)
    );

    // Rotation ignores the current owner, so a hit is always a different requester.
    rr_pick #(.N(N_REQ), .IDX_W(IDX_W)) u_pick_rot (
        .req   (others),
        .start (owner_inc),
        .found (rot_found),
        .idx   (rot_idx)
    );

    always_comb begin
        Gnt = '0;
        if (state == GRANT) begin
            Gnt[owner] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            owner     <= '0;
            ptr       <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_nxt;
        end
    end

    // Owner keeps the grant until its burst expires under contention or it stops requesting.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        burst_nxt = burst_cnt;
        unique case (state)
            IDLE: begin
                if (idle_found) begin
                    state_nxt = GRANT;
                    owner_nxt = idle_idx;
                    ptr_nxt   = wrap_inc(idle_idx);
                    burst_nxt = '0;
                end
            end
            GRANT: begin
                if (owner_req && ((burst_cnt < BURST_LIMIT) || !rot_found)) begin
                    if (burst_cnt != BURST_SAT) begin
                        burst_nxt = burst_cnt + BURST_CNT_W'(1);
                    end
                end else if (rot_found) begin
                    owner_nxt = rot_idx;
                    ptr_nxt   = wrap_inc(rot_idx);
                    burst_nxt = '0;
                end else begin
                    state_nxt = IDLE;
                    burst_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        endcase
    end

    assign slot_data = DataIn[owner*DATA_W +: DATA_W];

`ifdef DFF_SHARE_ARB_INVERT_EN
    assign slot_fx = ~slot_data;
`else
    assign slot_fx = slot_data;
`endif

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            DataOut  <= '0;
            OutId    <= '0;
            OutValid <= 1'b0;
        end else begin
            OutValid <= capture;
            if (capture) begin
                DataOut <= slot_fx;
                OutId   <= owner;
            end
        end
    end

endmodule

// File: tb/tb_dff_share_arb.sv
// Directed and randomized checks for dff_share_arb with default parameters (4 requesters, 8-bit data, burst 4).
// Expected data follows the DFF_SHARE_ARB_INVERT_EN build option when it is defined.
module tb_dff_share_arb;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  gnt;
    logic [7:0]  data_out;
    logic        out_valid;
    logic [1:0]  out_id;
    logic        busy;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] id;
        logic [7:0] data;
        logic       busy;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] din_word;

    dff_share_arb dut (
        .Clock    (clock),
        .Reset_n  (reset_n),
        .Req      (req),
        .DataIn   (data_in),
        .Gnt      (gnt),
        .DataOut  (data_out),
        .OutValid (out_valid),
        .OutId    (out_id),
        .Busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] fx(input logic [7:0] x);
`ifdef DFF_SHARE_ARB_INVERT_EN
        return ~x;
`else
        return x;
`endif
    endfunction

    function automatic logic [7:0] slot_of(input int k);
        return din_word[k*8 +: 8];
    endfunction

    task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d);
        req     = r;
        data_in = d;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int strobes;
        int exp_owner;
        int prev_owner;
        int wait_cnt [4];
        int max_wait;
        int onehot_viol;

        checks   = 0;
        failures = 0;
        din_word = 32'h33C3115A;
        reset_n  = 1'b0;
        req      = 4'b0000;
        data_in  = din_word;

        vecs[0] = '{4'b0001, 4'b0001, 1'b0, 2'd0, 8'h00,           1'b1};
        vecs[1] = '{4'b0001, 4'b0001, 1'b1, 2'd0, fx(slot_of(0)),  1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 1'b0, 2'd0, fx(slot_of(0)),  1'b0};
        vecs[3] = '{4'b1010, 4'b0010, 1'b0, 2'd0, fx(slot_of(0)),  1'b1};
        vecs[4] = '{4'b1010, 4'b0010, 1'b1, 2'd1, fx(slot_of(1)),  1'b1};
        vecs[5] = '{4'b1000, 4'b1000, 1'b0, 2'd1, fx(slot_of(1)),  1'b1};
        vecs[6] = '{4'b1000, 4'b1000, 1'b1, 2'd3, fx(slot_of(3)),  1'b1};
        vecs[7] = '{4'b0000, 4'b0000, 1'b0, 2'd3, fx(slot_of(3)),  1'b0};

        #58;
        checkOutput("reset_gnt",   gnt,       0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_data",  data_out,  0);
        checkOutput("reset_id",    out_id,    0);
        checkOutput("reset_busy",  busy,      0);
        #2;
        reset_n = 1'b1;

        // Single grant, capture, idle, then a mid-burst drop with hand-off.
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].req, din_word);
            checkOutput($sformatf("vec%0d_gnt", v),   gnt,       vecs[v].gnt);
            checkOutput($sformatf("vec%0d_valid", v), out_valid, vecs[v].valid);
            checkOutput($sformatf("vec%0d_id", v),    out_id,    vecs[v].id);
            checkOutput($sformatf("vec%0d_data", v),  data_out,  vecs[v].data);
            checkOutput($sformatf("vec%0d_busy", v),  busy,      vecs[v].busy);
        end

        // Lone requester keeps the grant indefinitely.
        applyStimulus(4'b0100, din_word);
        checkOutput("solo_first_gnt",   gnt,       4'b0100);
        checkOutput("solo_first_valid", out_valid, 0);
        strobes = 0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'b0100, din_word);
            if (out_valid) strobes++;
            checkOutput("solo_gnt",  gnt,      4'b0100);
            checkOutput("solo_id",   out_id,   2);
            checkOutput("solo_data", data_out, fx(slot_of(2)));
        end
        checkOutput("solo_strobes", strobes, 10);

        // Asynchronous reset in the middle of a burst.
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_gnt",   gnt,       0);
        checkOutput("midrst_valid", out_valid, 0);
        checkOutput("midrst_data",  data_out,  0);
        checkOutput("midrst_id",    out_id,    0);
        checkOutput("midrst_busy",  busy,      0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        applyStimulus(4'b1000, din_word);
        checkOutput("postrst_gnt",   gnt,       4'b1000);
        checkOutput("postrst_valid", out_valid, 0);
        applyStimulus(4'b0000, din_word);
        checkOutput("postrst_idle_gnt",   gnt,       0);
        checkOutput("postrst_idle_valid", out_valid, 0);

        // All four requesting: runs of four, starting at 0 because the pointer wrapped past 3.
        for (int e = 1; e <= 20; e++) begin
            applyStimulus(4'b1111, din_word);
            exp_owner = ((e - 1) / 4) % 4;
            checkOutput($sformatf("rot%0d_gnt", e), gnt, 32'(1) << exp_owner);
            if (e >= 2) begin
                prev_owner = ((e - 2) / 4) % 4;
                checkOutput($sformatf("rot%0d_valid", e), out_valid, 1);
                checkOutput($sformatf("rot%0d_id", e),    out_id,    prev_owner);
                checkOutput($sformatf("rot%0d_data", e),  data_out,  fx(slot_of(prev_owner)));
            end
        end

        // Random traffic: one-hot grant and bounded waiting.
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
        max_wait    = 0;
        onehot_viol = 0;
        for (int c = 0; c < 10000; c++) begin
            applyStimulus(4'($urandom_range(0, 15)), $urandom);
            if ($countones(gnt) > 1) onehot_viol++;
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !gnt[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
        checkOutput("rand_onehot_violations", onehot_viol, 0);
        checkOutput("rand_wait_within_bound", (max_wait <= 13), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_share_arb.md
DFF_SHARE_ARB -- requirements
Module: dff_share_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter DATA_W, default 8: datapath width in bits.
REQ-003 Parameter BURST_MAX, default 4: maximum consecutive granted cycles per owner while another requester is waiting, range 1..15.
REQ-004 Clock  input  1  rising-edge clock for all state.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 Req  input  N_REQ  per-requester request level.
REQ-007 DataIn  input  N_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
REQ-008 Gnt  output  N_REQ  registered grant, one-hot or zero.
REQ-009 DataOut  output  DATA_W  registered shared-datapath result.
REQ-010 OutValid  output  1  one-cycle strobe: DataOut/OutId updated this cycle.
REQ-011 OutId  output  max(1,clog2(N_REQ))  index of requester whose data is on DataOut.
REQ-012 Busy  output  1  high while the FSM is in GRANT.

Function
REQ-013 The FSM SHALL have two states: IDLE (Gnt=0) and GRANT (exactly one Gnt bit high).
REQ-014 In IDLE, if any Req bit is high, the winner SHALL be the first set Req bit searched upward from Ptr, modulo N_REQ, and the FSM SHALL enter GRANT with Gnt[winner] high on the next edge (Req->Gnt latency 1 cycle).
REQ-015 A capture SHALL occur on each edge where Gnt[k] and Req[k] are both high: DataOut <= f(DataIn slot k), OutId <= k, OutValid <= 1; otherwise OutValid <= 0 and DataOut/OutId hold (Gnt->OutValid latency 1 cycle).
REQ-016 A granted cycle with Req[owner] low SHALL produce no capture and SHALL return the FSM to IDLE, or hand off to another requester if one is requesting.
REQ-017 BurstCnt (4 bits) SHALL count consecutive granted cycles of the current owner and clear on every owner change or IDLE entry.
REQ-018 At each GRANT edge, the owner SHALL be kept if Req[owner]=1 and (BurstCnt < BURST_MAX-1 or no other Req bit is high); with no contender, BurstCnt SHALL saturate and not force rotation.
REQ-019 Otherwise, if another Req bit is high, the grant SHALL move to the first requesting index above the owner, modulo N_REQ, on the next edge with no idle gap; if no Req bit is high, the FSM SHALL go to IDLE.
REQ-020 Ptr SHALL update to (new owner + 1) mod N_REQ on every owner change and every IDLE->GRANT transition.
REQ-021 Req changes from requesters other than the owner SHALL NOT change Gnt before the next edge; Gnt SHALL never have more than one bit set.

Reset
REQ-022 Reset_n low SHALL asynchronously force state=IDLE, Gnt=0, DataOut=0, OutValid=0, OutId=0, Busy=0, Ptr=0, BurstCnt=0, including mid-burst.
REQ-023 After release, the first grant SHALL follow REQ-014 with Ptr=0.

Configuration
REQ-024 With macro DFF_SHARE_ARB_INVERT_EN defined, f(x) SHALL be bitwise ~x; with it undefined, f(x)=x (plain register). Arbitration timing SHALL be identical in both builds.

Structure
REQ-025 A shared package dff_share_arb_pkg SHALL hold the state enum (IDLE, GRANT), the BurstCnt width constant and the OutId width function.
REQ-026 The round-robin search SHALL be one sub-module, rr_pick (inputs: request vector, start index; outputs: found flag, index), instantiated twice: for IDLE entry and for rotation.

Verification
REQ-027 Reset 0..60 ns, Req=4'b0001, slot0=8'h5A -> Gnt=0001 one cycle after Req; next cycle OutValid=1, OutId=0, DataOut=8'hA5 (INVERT_EN) / 8'h5A (not defined).
REQ-028 Req=4'b1111 held for 20 cycles, BURST_MAX=4 -> owners 0,1,2,3,0 in runs of exactly 4 granted cycles, no gap cycles.
REQ-029 Only Req[2] held for 10 cycles -> Gnt=0100 continuously, 10 OutValid strobes, OutId=2.
REQ-030 Owner 1 drops Req during its 2nd granted cycle while Req[3]=1 -> no capture that cycle; Gnt=1000 on the next edge.
REQ-031 Reset_n pulsed low mid-burst -> all outputs 0 immediately; after release, Req=4'b1000 -> owner 3, then Ptr=0.
REQ-032 Random Req for 10k cycles -> Gnt one-hot or zero at all times, no requester waits more than (N_REQ-1)*BURST_MAX+1 cycles.
